serial_frame_receiver: RTL
==========================

# serial_frame_receiver

Serial-to-parallel receive endpoint for the framed serial link driven by the team's shift-register transmitter. It samples one bit per enabled clock, detects start/stop framing, and assembles WIDTH-bit words in either bit order. Completed words go into a 2-entry output buffer with a valid/ready handshake. The block sits at the receiving end of the link and feeds parallel consumers.

## Interface
- WIDTH, 4, data bits per frame (≥2)
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- ENB  in  1  bit-slot enable; S_IN is sampled only on CLK edges with ENB=1
- DIR  in  1  bit order: 0 = MSB first (left shift), 1 = LSB first (right shift)
- S_IN  in  1  serial line
- Q  out  WIDTH  head word of output buffer
- Q_VALID  out  1  Q holds an unread word
- Q_READY  in  1  consumer accepts Q this cycle
- FRAME_ERR  out  1  one-cycle pulse: bad stop bit
- OVERFLOW  out  1  sticky: a good word was dropped because the buffer was full

## Operation
- Frame on S_IN, counted in enabled cycles only: start bit (1), WIDTH data bits, stop bit (0). Idle line is 0.
- ENB=0 freezes the FSM, bit counter and shift register. The output handshake still runs.
- FSM states:
  - IDLE: enabled cycle with S_IN=1 → DATA; clear bit count; latch DIR for the whole frame. DIR changes mid-frame are ignored.
  - DATA: each enabled cycle shifts in S_IN.
    - DIR=0: sreg ← {sreg[WIDTH-2:0], S_IN}
    - DIR=1: sreg ← {S_IN, sreg[WIDTH-1:1]}
    - After the WIDTH-th bit → STOP.
  - STOP: enabled cycle with S_IN=0 → push sreg into the buffer. Enabled cycle with S_IN=1 → pulse FRAME_ERR and discard the word. Both cases → IDLE.
- Back-to-back frames: the next start bit may arrive on the enabled cycle after STOP.
- Output buffer: 2-entry FIFO.
  - Pop on Q_VALID && Q_READY.
  - Push when full with no simultaneous pop: word dropped, OVERFLOW set.
  - Push and pop in the same cycle when full: push accepted, no overflow.
  - Push and pop in the same cycle when holding 1 entry: count stays 1, Q advances to the new word.
  - Q_READY while empty: no effect.
- OVERFLOW clears only on reset.

## Timing
- Reset values: Q=0, Q_VALID=0, FRAME_ERR=0, OVERFLOW=0; FSM=IDLE, bit count=0, buffer empty.
- Reset takes effect immediately. Asserting it mid-frame discards the partial word and all buffered words.
- Frame length is WIDTH+2 enabled cycles.
- Q/Q_VALID update on the edge that samples the stop bit: visible in the next cycle when the buffer was empty. Latency is zero extra cycles.
- FRAME_ERR is high for exactly the one cycle after the bad stop-bit edge.
- Q is stable while Q_VALID=1 and Q_READY=0.
- Pop takes effect on the edge where Q_VALID && Q_READY. The next entry, if any, appears the following cycle.

## Structure
- Shared package serial_frame_pkg, shared with the transmitter:
  - FSM state encodings: IDLE, DATA, STOP
  - START_BIT=1'b1, STOP_BIT=1'b0
  - DIR encodings: DIR_LEFT=0, DIR_RIGHT=1
- Sub-module rx_word_fifo: 2-entry, WIDTH-wide, with push/pop/full/empty and the same-cycle push/pop rules above.
- Top level holds the FSM, bit counter ($clog2(WIDTH+1) bits), latched DIR, shift register and flag logic.

## Test plan
- WIDTH=4, DIR=0, ENB=1, Q_READY=1, S_IN=1,1,0,1,1,0 → Q=4'b1011 with Q_VALID=1 for one cycle after the stop edge, then Q_VALID=0.
- DIR=1, same S_IN sequence → Q=4'b1101. Toggling DIR to 0 mid-frame does not change the result.
- S_IN=1,0,1,0,1,1 (stop=1) → FRAME_ERR high for one cycle, Q_VALID stays 0. A following good frame (data 0110) is received correctly.
- ENB low on alternate cycles, with S_IN driven to garbage during ENB=0 cycles; enabled-cycle bits as in the first scenario → Q=4'b1011, identical to the first scenario.
- Q_READY=0, three good frames 0x3, 0x5, 0x9 → Q_VALID=1, Q=0x3, OVERFLOW=1 after the third. Then Q_READY=1 → Q shows 0x3, then 0x5, then Q_VALID=0; OVERFLOW stays 1.
- RST_N low after 2 data bits → all outputs 0 immediately. After release, a full frame with data 1001 yields Q=4'b1001.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - framing constants and FSM encodings shared by the serial link tx/rx
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } frame_state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/rx_word_fifo.sv
// rtl/rx_word_fifo.sv - 2-entry word buffer; slot0 is always the head so dout needs no read mux
module rx_word_fifo #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [1:0]       count;
  logic             pop_ok;

  assign pop_ok = pop && (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            slot0 <= din;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop_ok) begin
            slot0 <= din;
          end else if (push) begin
            slot1 <= din;
            count <= 2'd2;
          end else if (pop_ok) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          // A push without a pop is dropped here; the parent flags the overflow.
          if (pop_ok) begin
            slot0 <= slot1;
            if (push) slot1 <= din;
            else      count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  assign dout  = slot0;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - framed serial-to-parallel receiver with 2-word output buffer
module serial_frame_receiver
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             frame_err,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  frame_state_t     state;
  frame_state_t     state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic             dir_q;
  logic [WIDTH-1:0] sreg;
  logic             push;
  logic             bad_stop;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (enb) begin
      case (state)
        IDLE:    if (s_in == START_BIT) state_nxt = DATA;
        DATA:    if (bit_cnt == LAST_BIT) state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    push     = 1'b0;
    bad_stop = 1'b0;
    if (enb && state == STOP) begin
      if (s_in == STOP_BIT) push     = 1'b1;
      else                  bad_stop = 1'b1;
    end
  end

  // Bit order is captured at the start bit so a mid-frame DIR change cannot corrupt the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      dir_q   <= DIR_LEFT;
      sreg    <= '0;
    end else if (enb) begin
      if (state == IDLE && s_in == START_BIT) begin
        bit_cnt <= '0;
        dir_q   <= dir;
      end else if (state == DATA) begin
        bit_cnt <= bit_cnt + CW'(1);
        if (dir_q == DIR_RIGHT) sreg <= {s_in, sreg[WIDTH-1:1]};
        else                    sreg <= {sreg[WIDTH-2:0], s_in};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign q_valid = !fifo_empty;
  assign pop     = q_valid && q_ready;

  rx_word_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (sreg),
    .pop   (pop),
    .dout  (q),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
